// File: rtl/apb_txn_arbiter_if.sv
// Command port between the requester arbiter and the single APB master engine.
// The arbiter drives commands through the master modport; the engine uses the slave modport.
interface apb_txn_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ERR_WIDTH  = 2
);
  logic                  TRANSFER_o;
  logic                  RW_o;
  logic [ADDR_WIDTH-1:0] ADDR_o;
  logic [DATA_WIDTH-1:0] WDATA_o;
  logic                  DONE_i;
  logic [DATA_WIDTH-1:0] RDATA_i;
  logic [ERR_WIDTH-1:0]  FAIL_i;

  modport master (
    output TRANSFER_o, RW_o, ADDR_o, WDATA_o,
    input  DONE_i, RDATA_i, FAIL_i
  );

  modport slave (
    input  TRANSFER_o, RW_o, ADDR_o, WDATA_o,
    output DONE_i, RDATA_i, FAIL_i
  );
endinterface

// File: rtl/apb_txn_arbiter.sv
// Round-robin arbiter sharing one APB master command port among NUM_REQ requesters.
// One transaction in flight; a watchdog aborts a WAIT that never sees DONE.
module apb_txn_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ERR_WIDTH  = 2,
  parameter int WAIT_MAX   = 64
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            req_rw_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rsp_done_o,
  output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
  output logic [ERR_WIDTH-1:0]          rsp_fail_o,
  output logic                          busy_o,
  apb_txn_arbiter_if.master             cmd_if
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(WAIT_MAX);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ERR_WIDTH-1:0]  fail_q, fail_d;
  logic                  busy_q, busy_d;
  logic                  transfer_q, transfer_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  win_found;
  logic [IDX_W-1:0]      win_idx;
  int                    k;

  // Search starts at the pointer and wraps upward; first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    k         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!win_found && req_i[k]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(k);
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    rdata_d    = '0;
    fail_d     = '0;
    transfer_d = 1'b0;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d    = S_ISSUE;
          idx_d      = win_idx;
          gnt_d      = NUM_REQ'(1) << win_idx;
          transfer_d = 1'b1;
          rw_d       = req_rw_i[win_idx];
          addr_d     = req_addr_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d    = req_wdata_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
        ptr_d   = (idx_q == IDX_W'(NUM_REQ-1)) ? '0 : idx_q + IDX_W'(1);
      end
      S_WAIT: begin
        // A DONE on the expiry cycle still wins over the abort.
        if (cmd_if.DONE_i) begin
          state_d = S_RESP;
          done_d  = gnt_q;
          rdata_d = cmd_if.RDATA_i;
          fail_d  = cmd_if.FAIL_i;
        end else if (cnt_q == CNT_W'(WAIT_MAX-1)) begin
          state_d = S_RESP;
          done_d  = gnt_q;
          fail_d  = '1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      fail_q     <= '0;
      busy_q     <= 1'b0;
      transfer_q <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      fail_q     <= fail_d;
      busy_q     <= busy_d;
      transfer_q <= transfer_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign gnt_o             = gnt_q;
  assign rsp_done_o        = done_q;
  assign rsp_rdata_o       = rdata_q;
  assign rsp_fail_o        = fail_q;
  assign busy_o            = busy_q;
  assign cmd_if.TRANSFER_o = transfer_q;
  assign cmd_if.RW_o       = rw_q;
  assign cmd_if.ADDR_o     = addr_q;
  assign cmd_if.WDATA_o    = wdata_q;

endmodule

// File: tb/tb_apb_txn_arbiter.sv
// Scoreboard bench for apb_txn_arbiter: expected responses are queued when a
// transaction is launched and popped when the arbiter pulses rsp_done_o.
module tb_apb_txn_arbiter;
  localparam int NR = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int EW = 2;
  localparam int WM = 16;

  logic             PCLK = 1'b0;
  logic             PRESETn = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [NR-1:0]    req_rw = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]    gnt_o;
  logic [NR-1:0]    rsp_done_o;
  logic [DW-1:0]    rsp_rdata_o;
  logic [EW-1:0]    rsp_fail_o;
  logic             busy_o;

  apb_txn_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_WIDTH(EW)) bus ();

  apb_txn_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_WIDTH(EW), .WAIT_MAX(WM)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_i(req), .req_rw_i(req_rw), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .gnt_o(gnt_o), .rsp_done_o(rsp_done_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_fail_o(rsp_fail_o), .busy_o(busy_o), .cmd_if(bus)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [NR-1:0] owner;
    logic [DW-1:0] rdata;
    logic [EW-1:0] fail;
  } rsp_t;

  rsp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_req(input int idx, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_rw[idx]           = rw;
    req_addr[idx*AW +: AW]  = a;
    req_wdata[idx*DW +: DW] = d;
  endtask

  task automatic wait_transfer(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.TRANSFER_o === 1'b1) begin
        ok = 1'b1;
        n  = i;
        return;
      end
      tick();
    end
  endtask

  task automatic wait_rsp(input int budget, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < budget; i++) begin
      if (rsp_done_o !== '0) begin
        ok = 1'b1;
        n  = i;
        return;
      end
      tick();
    end
  endtask

  task automatic pulse_done(input int delay, input logic [DW-1:0] rd, input logic [EW-1:0] fl);
    repeat (delay) tick();
    bus.DONE_i  = 1'b1;
    bus.RDATA_i = rd;
    bus.FAIL_i  = fl;
    tick();
    bus.DONE_i  = 1'b0;
    bus.RDATA_i = '0;
    bus.FAIL_i  = '0;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    repeat (3) tick();
    tests_run++; if ({gnt_o, rsp_done_o} !== '0) begin tests_failed++; $display("FAIL reset_gnt_done: got %b want 0", {gnt_o, rsp_done_o}); end
    tests_run++; if ({rsp_rdata_o, rsp_fail_o, busy_o} !== '0) begin tests_failed++; $display("FAIL reset_rsp_busy: got %h want 0", {rsp_rdata_o, rsp_fail_o, busy_o}); end
    tests_run++; if ({bus.TRANSFER_o, bus.RW_o, bus.ADDR_o, bus.WDATA_o} !== '0) begin tests_failed++; $display("FAIL reset_cmd: got %h want 0", {bus.TRANSFER_o, bus.RW_o, bus.ADDR_o, bus.WDATA_o}); end
    PRESETn = 1'b1;
    tick();
  endtask

  task automatic test_read();
    bit ok; int n; rsp_t e;
    set_req(1, 1'b0, 16'h0040, 16'h0000);
    req = 4'b0010;
    exp_q.push_back('{4'b0010, 16'hA5A5, 2'b00});
    wait_transfer(ok, n);
    tests_run++; if (!ok || n != 1) begin tests_failed++; $display("FAIL read_issue_latency: got ok=%0d n=%0d want ok=1 n=1", ok, n); end
    tests_run++; if ({bus.RW_o, bus.ADDR_o} !== {1'b0, 16'h0040}) begin tests_failed++; $display("FAIL read_cmd: got rw=%b addr=%h want rw=0 addr=0040", bus.RW_o, bus.ADDR_o); end
    tests_run++; if (gnt_o !== 4'b0010) begin tests_failed++; $display("FAIL read_gnt: got %b want 0010", gnt_o); end
    req = '0;
    tick();
    tests_run++; if (bus.TRANSFER_o !== 1'b0) begin tests_failed++; $display("FAIL read_transfer_width: got %b want 0", bus.TRANSFER_o); end
    pulse_done(2, 16'hA5A5, 2'b00);
    wait_rsp(5, ok, n);
    tests_run++; if (!ok || n != 0) begin tests_failed++; $display("FAIL read_rsp_latency: got ok=%0d n=%0d want ok=1 n=0", ok, n); end
    e = exp_q.pop_front();
    tests_run++; if ({rsp_done_o, rsp_rdata_o, rsp_fail_o} !== {e.owner, e.rdata, e.fail}) begin tests_failed++; $display("FAIL read_rsp: got done=%b rdata=%h fail=%b want done=%b rdata=%h fail=%b", rsp_done_o, rsp_rdata_o, rsp_fail_o, e.owner, e.rdata, e.fail); end
    tick();
    tests_run++; if ({gnt_o, rsp_done_o, rsp_rdata_o, busy_o} !== '0) begin tests_failed++; $display("FAIL read_return_idle: got %h want 0", {gnt_o, rsp_done_o, rsp_rdata_o, busy_o}); end
  endtask

  task automatic test_round_robin();
    bit ok; int n; rsp_t e; int exp_ptr;
    logic [NR-1:0] exp_gnt;
    PRESETn = 1'b0;
    tick();
    PRESETn = 1'b1;
    for (int r = 0; r < NR; r++) set_req(r, 1'b0, 16'h0100 + 16'(r), 16'h0000);
    req = '1;
    exp_ptr = 0;
    for (int t = 0; t < 8; t++) begin
      exp_gnt = NR'(1) << exp_ptr;
      wait_transfer(ok, n);
      tests_run++; if (!ok || gnt_o !== exp_gnt) begin tests_failed++; $display("FAIL rr_gnt_%0d: got ok=%0d gnt=%b want gnt=%b", t, ok, gnt_o, exp_gnt); end
      tests_run++; if (bus.ADDR_o !== 16'h0100 + 16'(exp_ptr)) begin tests_failed++; $display("FAIL rr_addr_%0d: got %h want %h", t, bus.ADDR_o, 16'h0100 + 16'(exp_ptr)); end
      exp_q.push_back('{exp_gnt, 16'hC000 + 16'(t), 2'b00});
      pulse_done(1, 16'hC000 + 16'(t), 2'b00);
      wait_rsp(5, ok, n);
      e = exp_q.pop_front();
      tests_run++; if (!ok || {rsp_done_o, rsp_rdata_o} !== {e.owner, e.rdata}) begin tests_failed++; $display("FAIL rr_rsp_%0d: got ok=%0d done=%b rdata=%h want done=%b rdata=%h", t, ok, rsp_done_o, rsp_rdata_o, e.owner, e.rdata); end
      exp_ptr = (exp_ptr + 1) % NR;
    end
    req = '0;
    repeat (2) tick();
  endtask

  task automatic test_write_error();
    bit ok; int n; rsp_t e;
    set_req(2, 1'b1, 16'h0088, 16'h1234);
    req = 4'b0100;
    exp_q.push_back('{4'b0100, 16'hBEEF, 2'b01});
    wait_transfer(ok, n);
    tests_run++; if (!ok || {bus.RW_o, bus.WDATA_o, bus.ADDR_o} !== {1'b1, 16'h1234, 16'h0088}) begin tests_failed++; $display("FAIL wr_cmd: got ok=%0d rw=%b wdata=%h addr=%h want rw=1 wdata=1234 addr=0088", ok, bus.RW_o, bus.WDATA_o, bus.ADDR_o); end
    req = '0;
    pulse_done(2, 16'hBEEF, 2'b01);
    wait_rsp(5, ok, n);
    e = exp_q.pop_front();
    tests_run++; if (!ok || rsp_done_o !== e.owner) begin tests_failed++; $display("FAIL wr_owner: got ok=%0d done=%b want %b", ok, rsp_done_o, e.owner); end
    tests_run++; if ({rsp_fail_o, rsp_rdata_o} !== {e.fail, e.rdata}) begin tests_failed++; $display("FAIL wr_fail: got fail=%b rdata=%h want fail=%b rdata=%h", rsp_fail_o, rsp_rdata_o, e.fail, e.rdata); end
    set_req(2, 1'b0, 16'h0000, 16'h0000);
    tick();
  endtask

  task automatic test_watchdog();
    bit ok; int n; rsp_t e; bit bad;
    set_req(3, 1'b0, 16'h0300, 16'h0000);
    req = 4'b1000;
    exp_q.push_back('{4'b1000, 16'h0000, 2'b11});
    wait_transfer(ok, n);
    req = '0;
    bus.RDATA_i = 16'hDEAD;
    wait_rsp(40, ok, n);
    bus.RDATA_i = '0;
    tests_run++; if (!ok || n != WM + 1) begin tests_failed++; $display("FAIL wd_latency: got ok=%0d n=%0d want n=%0d", ok, n, WM + 1); end
    e = exp_q.pop_front();
    tests_run++; if ({rsp_done_o, rsp_rdata_o, rsp_fail_o} !== {e.owner, e.rdata, e.fail}) begin tests_failed++; $display("FAIL wd_rsp: got done=%b rdata=%h fail=%b want done=%b rdata=%h fail=%b", rsp_done_o, rsp_rdata_o, rsp_fail_o, e.owner, e.rdata, e.fail); end
    repeat (4) tick();
    pulse_done(0, 16'h7777, 2'b00);
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_done_o !== '0 || busy_o !== 1'b0) bad = 1'b1;
      tick();
    end
    tests_run++; if (bad !== 1'b0) begin tests_failed++; $display("FAIL wd_late_done_ignored: got bad=%b want 0", bad); end
  endtask

  task automatic test_reset_in_wait();
    bit ok; int n; rsp_t e;
    set_req(1, 1'b0, 16'h0011, 16'h0000);
    req = 4'b0010;
    wait_transfer(ok, n);
    tests_run++; if (!ok || gnt_o !== 4'b0010) begin tests_failed++; $display("FAIL rst_pre_gnt: got ok=%0d gnt=%b want 0010", ok, gnt_o); end
    req = '0;
    repeat (2) tick();
    PRESETn = 1'b0;
    tick();
    PRESETn = 1'b1;
    tests_run++; if ({gnt_o, rsp_done_o, busy_o, bus.TRANSFER_o, bus.RW_o} !== '0) begin tests_failed++; $display("FAIL rst_ctrl: got %b want 0", {gnt_o, rsp_done_o, busy_o, bus.TRANSFER_o, bus.RW_o}); end
    tests_run++; if ({bus.ADDR_o, bus.WDATA_o, rsp_rdata_o, rsp_fail_o} !== '0) begin tests_failed++; $display("FAIL rst_data: got %h want 0", {bus.ADDR_o, bus.WDATA_o, rsp_rdata_o, rsp_fail_o}); end
    set_req(0, 1'b0, 16'h0A00, 16'h0000);
    set_req(3, 1'b0, 16'h0A03, 16'h0000);
    req = 4'b1001;
    exp_q.push_back('{4'b0001, 16'h1111, 2'b00});
    wait_transfer(ok, n);
    tests_run++; if (!ok || {gnt_o, bus.ADDR_o} !== {4'b0001, 16'h0A00}) begin tests_failed++; $display("FAIL rst_next_gnt: got ok=%0d gnt=%b addr=%h want gnt=0001 addr=0a00", ok, gnt_o, bus.ADDR_o); end
    req = '0;
    pulse_done(1, 16'h1111, 2'b00);
    wait_rsp(5, ok, n);
    e = exp_q.pop_front();
    tests_run++; if (!ok || {rsp_done_o, rsp_rdata_o} !== {e.owner, e.rdata}) begin tests_failed++; $display("FAIL rst_next_rsp: got ok=%0d done=%b rdata=%h want done=%b rdata=%h", ok, rsp_done_o, rsp_rdata_o, e.owner, e.rdata); end
    tick();
  endtask

  task automatic test_boundary();
    bit ok; int n; rsp_t e;
    set_req(2, 1'b0, 16'h0010, 16'h0000);
    req = 4'b0100;
    exp_q.push_back('{4'b0100, 16'h5A5A, 2'b10});
    wait_transfer(ok, n);
    req = '0;
    set_req(2, 1'b1, 16'h00FF, 16'h9999);
    pulse_done(WM, 16'h5A5A, 2'b10);
    wait_rsp(5, ok, n);
    e = exp_q.pop_front();
    tests_run++; if (!ok || n != 0) begin tests_failed++; $display("FAIL bnd_rsp_latency: got ok=%0d n=%0d want ok=1 n=0", ok, n); end
    tests_run++; if ({rsp_done_o, rsp_rdata_o, rsp_fail_o} !== {e.owner, e.rdata, e.fail}) begin tests_failed++; $display("FAIL bnd_rsp: got done=%b rdata=%h fail=%b want done=%b rdata=%h fail=%b", rsp_done_o, rsp_rdata_o, rsp_fail_o, e.owner, e.rdata, e.fail); end
    tests_run++; if ({bus.ADDR_o, bus.RW_o} !== {16'h0010, 1'b0}) begin tests_failed++; $display("FAIL bnd_addr_held: got addr=%h rw=%b want addr=0010 rw=0", bus.ADDR_o, bus.RW_o); end
    repeat (2) tick();
  endtask

  initial begin
    bus.DONE_i  = 1'b0;
    bus.RDATA_i = '0;
    bus.FAIL_i  = '0;
    test_reset();
    test_read();
    test_round_robin();
    test_write_error();
    test_watchdog();
    test_reset_in_wait();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1);
  end
endmodule
